// File: rtl/aes_keyexp_ctrl.sv
// AES-128 key-expansion sequencer: steps an external round-key scheduler through
// rounds 1..NROUNDS, stores all round keys, and serves them on a random-access read port.
// Optional scheduler-ready timeout is enabled by defining KEYEXP_TIMEOUT_EN.
module aes_keyexp_ctrl #(
  parameter int NROUNDS = 10,
  parameter int TMO_CYC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic         error_o,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o,
  output logic         ks_start_o,
  output logic [3:0]   ks_round_o,
  output logic [127:0] ks_last_key_o,
  input  logic [127:0] ks_new_key_i,
  input  logic         ks_ready_i
);

  // Scheduler handshake: ks_start_o is a single-cycle request; ks_round_o and
  // ks_last_key_o stay stable until the cycle ks_ready_i (single-cycle valid) is seen.
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   cur_key_q, cur_key_d;
  logic           kv_q, kv_d;
  logic [127:0]   rk_q [0:NROUNDS];
  logic           rk_we;
  logic [3:0]     rk_waddr;
  logic [127:0]   rk_wdata;
`ifdef KEYEXP_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);
  logic           err_q, err_d;
  logic [3:0]     wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    cur_key_d = cur_key_q;
    kv_d      = kv_q;
    rk_we     = 1'b0;
    rk_waddr  = rnd_q;
    rk_wdata  = ks_new_key_i;
`ifdef KEYEXP_TIMEOUT_EN
    err_d     = err_q;
    wcnt_d    = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          rk_we     = 1'b1;
          rk_waddr  = 4'd0;
          rk_wdata  = key_i;
          cur_key_d = key_i;
          rnd_d     = 4'd1;
          kv_d      = 1'b0;
`ifdef KEYEXP_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
`ifdef KEYEXP_TIMEOUT_EN
        wcnt_d  = 4'd0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ks_ready_i) begin
          rk_we     = 1'b1;
          cur_key_d = ks_new_key_i;
          if (rnd_q == LAST) begin
            state_d = S_DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = S_START;
          end
        end
`ifdef KEYEXP_TIMEOUT_EN
        // Ready wins over a timeout landing in the same cycle.
        else if (wcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
`endif
      end
      S_DONE: begin
        kv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rnd_q     <= 4'd0;
      cur_key_q <= '0;
      kv_q      <= 1'b0;
`ifdef KEYEXP_TIMEOUT_EN
      err_q     <= 1'b0;
      wcnt_q    <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      cur_key_q <= cur_key_d;
      kv_q      <= kv_d;
`ifdef KEYEXP_TIMEOUT_EN
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  // Key storage is deliberately not reset; keys_valid_o qualifies its contents.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_waddr] <= rk_wdata;
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign ks_start_o    = (state_q == S_START);
  assign keys_valid_o  = kv_q;
  assign ks_round_o    = rnd_q;
  assign ks_last_key_o = cur_key_q;
  assign rd_key_o      = (rd_round_i <= LAST) ? rk_q[rd_round_i] : '0;
`ifdef KEYEXP_TIMEOUT_EN
  assign error_o       = err_q;
`else
  assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_keyexp_ctrl.sv
// Bench for aes_keyexp_ctrl with a behavioural 5-cycle AES-128 key scheduler and S-box.
// Timeout scenario is compiled in when KEYEXP_TIMEOUT_EN is defined.
module tb_aes_keyexp_ctrl;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, done_o, keys_valid_o, error_o;
  logic [3:0]   rd_round_i = 4'd0;
  logic [127:0] rd_key_o;
  logic         ks_start_o;
  logic [3:0]   ks_round_o;
  logic [127:0] ks_last_key_o;
  logic [127:0] ks_new_key_i;
  logic         ks_ready_i;

  logic         mdl_ready = 1'b0, inj_ready = 1'b0, withhold = 1'b0;
  logic [127:0] mdl_key = '0, inj_key = '0;
  logic [7:0]   sbox [256];
  logic [127:0] exp_q [$];
  int           errors = 0;
  int           checks = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  assign ks_ready_i   = mdl_ready | inj_ready;
  assign ks_new_key_i = inj_ready ? inj_key : mdl_key;

  aes_keyexp_ctrl dut (
    .clk(clk), .reset(reset), .load_i(load_i), .key_i(key_i),
    .busy_o(busy_o), .done_o(done_o), .keys_valid_o(keys_valid_o), .error_o(error_o),
    .rd_round_i(rd_round_i), .rd_key_o(rd_key_o),
    .ks_start_o(ks_start_o), .ks_round_o(ks_round_o), .ks_last_key_o(ks_last_key_o),
    .ks_new_key_i(ks_new_key_i), .ks_ready_i(ks_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] next_key(input logic [127:0] prev, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    logic [7:0]  rcon;
    w0 = prev[127:96]; w1 = prev[95:64]; w2 = prev[63:32]; w3 = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
    case (r)
      4'd1: rcon = 8'h01; 4'd2: rcon = 8'h02; 4'd3: rcon = 8'h04; 4'd4: rcon = 8'h08;
      4'd5: rcon = 8'h10; 4'd6: rcon = 8'h20; 4'd7: rcon = 8'h40; 4'd8: rcon = 8'h80;
      4'd9: rcon = 8'h1b; 4'd10: rcon = 8'h36; default: rcon = 8'h00;
    endcase
    n0 = w0 ^ sub ^ {rcon, 24'h0};
    n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Scheduler model: 5-cycle latency from start, re-reads its inputs at result time.
  initial begin
    @(posedge clk); #1;
    forever begin
      if (ks_start_o && !withhold) begin
        repeat (5) @(posedge clk);
        #1;
        mdl_key   = next_key(ks_last_key_o, ks_round_o);
        mdl_ready = 1'b1;
        @(posedge clk); #1;
        mdl_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Drives one load (caller sits at #1 after an edge) and observes until done_o.
  task automatic expand(input logic [127:0] key, input int extra_at, output int done_rel,
                        output int starts, output int dbl, output int unstable,
                        output int kv_seen, output logic [127:0] rk1_early);
    logic p_start, p_act;
    logic [3:0] p_rnd;
    logic [127:0] p_key;
    done_rel = -1; starts = 0; dbl = 0; unstable = 0; kv_seen = 0; rk1_early = '0;
    p_start = 1'b0; p_act = 1'b0; p_rnd = 4'd0; p_key = '0;
    load_i = 1'b1; key_i = key;
    for (int k = 1; k <= 150 && done_rel < 0; k++) begin
      @(posedge clk); #1;
      load_i = (k == extra_at);
      key_i  = (k == extra_at) ? ~key : key;
      if (k == 7) rk1_early = rd_key_o;
      if (ks_start_o) begin
        starts++;
        if (p_start) dbl++;
      end
      if (busy_o && !ks_start_o && !done_o && p_act)
        if (ks_round_o !== p_rnd || ks_last_key_o !== p_key) unstable++;
      if (keys_valid_o) kv_seen++;
      if (done_o) done_rel = k;
      if (k == 6) rd_round_i = 4'd1;
      p_start = ks_start_o; p_act = busy_o && !done_o;
      p_rnd = ks_round_o; p_key = ks_last_key_o;
    end
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (keys_valid_o !== 1'b0) begin errors++; $display("FAIL rst_kv got=%b exp=0", keys_valid_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", error_o); end
    checks++; if (ks_start_o !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", ks_start_o); end
    checks++; if (ks_round_o !== 4'd0) begin errors++; $display("FAIL rst_round got=%0d exp=0", ks_round_o); end
    checks++; if (ks_last_key_o !== '0) begin errors++; $display("FAIL rst_lastkey got=%h exp=0", ks_last_key_o); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_expand();
    int dr, st, dbl, un, kv;
    logic [127:0] rk1e;
    expand(FIPS_KEY, 20, dr, st, dbl, un, kv, rk1e);
    checks++; if (dr !== 61) begin errors++; $display("FAIL fips_done_cycle got=%0d exp=61", dr); end
    checks++; if (st !== 10) begin errors++; $display("FAIL fips_start_count got=%0d exp=10", st); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL fips_start_width got=%0d exp=0", dbl); end
    checks++; if (un !== 0) begin errors++; $display("FAIL fips_hold_stable got=%0d exp=0", un); end
    checks++; if (kv !== 0) begin errors++; $display("FAIL fips_kv_early got=%0d exp=0", kv); end
    checks++; if (rk1e !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1_early got=%h exp=%h", rk1e, FIPS_RK1); end
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fips_busy_end got=%b exp=0", busy_o); end
    checks++; if (keys_valid_o !== 1'b1) begin errors++; $display("FAIL fips_kv_end got=%b exp=1", keys_valid_o); end
    rd_round_i = 4'd1; #1;
    checks++; if (rd_key_o !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got=%h exp=%h", rd_key_o, FIPS_RK1); end
    rd_round_i = 4'd10; #1;
    checks++; if (rd_key_o !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10 got=%h exp=%h", rd_key_o, FIPS_RK10); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_sweep();
    logic [127:0] sched [11];
    logic [127:0] e;
    sched[0] = FIPS_KEY;
    for (int r = 1; r <= 10; r++) sched[r] = next_key(sched[r-1], 4'(r));
    for (int r = 10; r >= 0; r--) exp_q.push_back(sched[r]);
    for (int r = 10; r >= 0; r--) begin
      rd_round_i = 4'(r); #1;
      e = exp_q.pop_front();
      checks++; if (rd_key_o !== e) begin errors++; $display("FAIL sweep_rk%0d got=%h exp=%h", r, rd_key_o, e); end
    end
    rd_round_i = 4'd11; #1;
    checks++; if (rd_key_o !== '0) begin errors++; $display("FAIL sweep_idx11 got=%h exp=0", rd_key_o); end
    rd_round_i = 4'd15; #1;
    checks++; if (rd_key_o !== '0) begin errors++; $display("FAIL sweep_idx15 got=%h exp=0", rd_key_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ready();
    inj_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    inj_ready = 1'b1;
    @(posedge clk); #1;
    inj_ready = 1'b0;
    checks++; if (busy_o !== 1'b0 || ks_start_o !== 1'b0) begin errors++; $display("FAIL idle_ready_state got=%b%b exp=00", busy_o, ks_start_o); end
    checks++; if (keys_valid_o !== 1'b1) begin errors++; $display("FAIL idle_ready_kv got=%b exp=1", keys_valid_o); end
    rd_round_i = 4'd10; #1;
    checks++; if (rd_key_o !== FIPS_RK10) begin errors++; $display("FAIL idle_ready_rk10 got=%h exp=%h", rd_key_o, FIPS_RK10); end
    rd_round_i = 4'd0; #1;
    checks++; if (rd_key_o !== FIPS_KEY) begin errors++; $display("FAIL idle_ready_rk0 got=%h exp=%h", rd_key_o, FIPS_KEY); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dr, st, dbl, un, kv;
    logic [127:0] rk1e;
    load_i = 1'b1; key_i = FIPS_KEY;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      load_i = 1'b0;
      if (k == 30) reset = 1'b0;
    end
    checks++; if ({busy_o, done_o, keys_valid_o, error_o, ks_start_o} !== 5'b0) begin
      errors++; $display("FAIL mid_rst_flags got=%b exp=00000", {busy_o, done_o, keys_valid_o, error_o, ks_start_o}); end
    checks++; if (ks_round_o !== 4'd0 || ks_last_key_o !== '0) begin
      errors++; $display("FAIL mid_rst_ks got=%0d/%h exp=0/0", ks_round_o, ks_last_key_o); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got=%b exp=0", busy_o); end
    expand(SEQ_KEY, 0, dr, st, dbl, un, kv, rk1e);
    checks++; if (dr !== 61) begin errors++; $display("FAIL seq_done_cycle got=%0d exp=61", dr); end
    @(posedge clk); #1;
    checks++; if (keys_valid_o !== 1'b1) begin errors++; $display("FAIL seq_kv got=%b exp=1", keys_valid_o); end
    rd_round_i = 4'd10; #1;
    checks++; if (rd_key_o !== SEQ_RK10) begin errors++; $display("FAIL seq_rk10 got=%h exp=%h", rd_key_o, SEQ_RK10); end
    rd_round_i = 4'd0; #1;
    checks++; if (rd_key_o !== SEQ_KEY) begin errors++; $display("FAIL seq_rk0 got=%h exp=%h", rd_key_o, SEQ_KEY); end
    @(posedge clk); #1;
  endtask

`ifdef KEYEXP_TIMEOUT_EN
  task automatic test_timeout();
    int s, dr, st, dbl, un, kv, done_seen;
    logic [127:0] rk1e;
    s = -1; done_seen = 0;
    withhold = 1'b1;
    load_i = 1'b1; key_i = SEQ_KEY;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      load_i = 1'b0;
      if (done_o) done_seen++;
      if (ks_start_o && s < 0) s = k;
      if (s >= 0 && k == s + 7) begin
        checks++; if (error_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL tmo_early got=%b%b exp=01", error_o, busy_o); end
      end
      if (s >= 0 && k == s + 9) begin
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", error_o); end
        checks++; if (busy_o !== 1'b0 || keys_valid_o !== 1'b0) begin errors++; $display("FAIL tmo_state got=%b%b exp=00", busy_o, keys_valid_o); end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL tmo_done got=%0d exp=0", done_seen); end
        break;
      end
    end
    checks++; if (s < 0) begin errors++; $display("FAIL tmo_start got=none exp=pulse"); end
    withhold = 1'b0;
    @(posedge clk); #1;
    expand(SEQ_KEY, 0, dr, st, dbl, un, kv, rk1e);
    checks++; if (dr !== 61 || error_o !== 1'b0) begin errors++; $display("FAIL tmo_recover got=%0d/%b exp=61/0", dr, error_o); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    logic [127:0] rows [16];
    logic [127:0] t;
    rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76; rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115; rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84; rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8; rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973; rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    rows[10] = 128'he0323a0a4906245cc2d3ac629195e479; rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a; rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df; rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int i = 0; i < 16; i++) begin
      t = rows[i];
      for (int j = 0; j < 16; j++) sbox[i*16+j] = t[127-8*j -: 8];
    end
    test_reset();
    test_fips_expand();
    test_read_sweep();
    test_idle_ready();
    test_reset_mid();
`ifdef KEYEXP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
